imm_expand_stage: RTL

Parametrised, registered immediate-expansion stage for the 32-bit MIPS datapath. It generalises the fixed 16-to-32 LUI placement to configurable widths and four expansion modes. It sits between decode and execute and carries a destination tag with each result. A 2-entry buffer with valid/ready handshakes on both sides absorbs execute-side stalls, and a synchronous flush discards in-flight entries on redirect.

---
 rtl/imm_expand_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/imm_expand_stage.sv
// Immediate-expansion stage between decode and execute.
// Expands a raw immediate according to a 2-bit mode (zero-extend, sign-extend,
// upper placement, branch offset) and queues the result with its destination
// tag in a 2-entry in-order buffer with valid/ready handshakes on both sides.
module imm_expand_stage #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    // Branch mode needs two spare bits above the immediate for the shift.
    if (IMM_W < 1 || DATA_W < IMM_W + 2) begin : g_param_check
        $fatal(1, "imm_expand_stage: need IMM_W >= 1 and DATA_W >= IMM_W+2");
    end

    localparam logic [1:0] MODE_ZEXT   = 2'b00;
    localparam logic [1:0] MODE_SEXT   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    // Pure bit placement: no carries, so no flags are produced.
    function automatic logic [DATA_W-1:0] expand_imm(
        input logic [IMM_W-1:0] imm,
        input logic [1:0]       mode
    );
        logic signed [IMM_W-1:0]  imm_s;
        logic signed [DATA_W-1:0] sext;
        logic [DATA_W-1:0]        res;
        imm_s = $signed(imm);
        sext  = DATA_W'(imm_s);
        res   = '0;
        case (mode)
            MODE_ZEXT:   res = {{(DATA_W-IMM_W){1'b0}}, imm};
            MODE_SEXT:   res = sext;
            MODE_UPPER:  res = {imm, {(DATA_W-IMM_W){1'b0}}};
            MODE_BRANCH: res = {sext[DATA_W-3:0], 2'b00};
            default:     res = '0;
        endcase
        return res;
    endfunction

    logic [DATA_W-1:0] r_data0, r_data1;
    logic [TAG_W-1:0]  r_tag0,  r_tag1;
    logic [1:0]        r_count;

    logic [DATA_W-1:0] w_exp;
    logic              w_push;
    logic              w_pop;

    // Handshake decode and combinational expansion of the incoming immediate.
    always_comb begin
        in_ready  = (r_count < 2'd2) && !reset;
        out_valid = (r_count != 2'd0);
        out_data  = out_valid ? r_data0 : '0;
        out_tag   = out_valid ? r_tag0  : '0;
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
        w_exp     = expand_imm(in_imm, in_mode);
    end

    // Buffer update: reset, then flush, then push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count <= 2'd0;
            r_data0 <= '0;
            r_tag0  <= '0;
            r_data1 <= '0;
            r_tag1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= w_exp;
                        r_tag0  <= in_tag;
                    end else begin
                        r_data1 <= w_exp;
                        r_tag1  <= in_tag;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_tag0  <= r_tag1;
                    r_data1 <= '0;
                    r_tag1  <= '0;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry held: the head leaves and
                    // the new entry takes its place.
                    r_data0 <= w_exp;
                    r_tag0  <= in_tag;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
